hv_cfg_reg_bank: RTL and testbench
==================================

# hv_cfg_reg_bank

Parametrised configuration register bank for the HV-side driver. It holds REG_NUM configuration registers of DW bits: config1..config12, trim, dvdt, adc and test registers. Writes land in a shadow copy. An explicit commit transfers the whole shadow copy atomically to the active copy that drives the analog/digital config fields. The active copy is parity-protected and continuously scrubbed, so corrupted configuration is flagged to the fault logic.

## Interface
Parameters
- REG_NUM, 32, number of registers; legal range 2..256
- DW, 8, register data width
- AW, $clog2(REG_NUM), address width
- RST_VAL, '0, flat REG_NUM*DW reset-default vector; register i occupies bits [i*DW +: DW]

Ports
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- wr_req  in  1  write strobe, one register per cycle
- wr_addr  in  AW  write address
- wr_data  in  DW  write data
- wr_lock  in  1  write protect; while high, writes are ignored
- rd_req  in  1  read strobe
- rd_addr  in  AW  read address
- rd_sel  in  1  0 = read shadow copy, 1 = read active copy
- rd_data  out  DW  read data
- rd_vld  out  1  read data valid
- commit  in  1  single-cycle pulse; copies shadow to active
- acc_err  out  1  pulse: out-of-range address, or write while locked
- reg_act  out  REG_NUM*DW  active configuration, flat
- par_inj  in  1  test only: flip the stored parity bit of register wr_addr
- err_clr  in  1  clears par_err
- par_err  out  1  sticky parity error
- par_err_addr  out  AW  address of the first detected error

## Operation
- Reset: shadow and active both load RST_VAL; parity bits are recomputed from RST_VAL. rd_data=0, rd_vld=0, acc_err=0, par_err=0, par_err_addr=0, scrub counter=0.
- Write
  - Accepted when wr_req=1, wr_lock=0 and wr_addr<REG_NUM.
  - The shadow register updates on the next edge.
  - If wr_lock=1 or the address is out of range, the write is ignored and acc_err pulses 1 cycle.
- Read
  - rd_data is registered; rd_vld=1 one cycle after rd_req.
  - An out-of-range read returns 0 with rd_vld=1 and pulses acc_err.
  - rd_vld and rd_data return to 0 when there is no request.
- Commit
  - On commit=1: active[i] <= shadow[i] for all i, and each parity bit <= ^shadow[i] (even parity).
  - A write in the same cycle as commit is included in the committed value (forwarded).
  - Commit is not blocked by wr_lock.
- Parity injection: par_inj=1 inverts the stored parity bit of register wr_addr. Injection does not need wr_req.
- Scrub
  - The counter steps 0..REG_NUM-1 and wraps to 0, advancing one register per cycle.
  - Each cycle it checks ^active[cnt] against par[cnt].
  - On a mismatch: par_err <= 1. par_err_addr is captured only if par_err was 0 (first error wins).
  - err_clr in the same cycle as a new mismatch: set wins, and the new address is captured.
- Commit and scrub of the same register in the same cycle: the check uses the pre-commit values.

## Timing
- Write to shadow: 1 cycle.
- Commit to reg_act: 1 cycle.
- Read latency: 1 cycle; back-to-back reads are allowed every cycle.
- Scrub: worst-case detection is REG_NUM+1 cycles after corruption.
- acc_err: registered, asserted 1 cycle after the offending request.
- Reset mid-operation: all state returns to the reset values on the next edge; a pending read produces no rd_vld.

## Structure
- The shared package holds:
  - the register address constants (CFG1_ADDR..CMP_ADJ_VREG_ADDR)
  - the default-value constant vector used for RST_VAL
  - the existing per-register packed structs; consumers cast reg_act slices to these structs
- Sub-module hv_cfg_scrub: scrub counter, parity compare, sticky error and address capture. It takes the active and parity vectors as inputs.

## Test plan
- Reset with RST_VAL having register 3 = 0x5A → reg_act[3]=0x5A, par_err=0, rd (rd_sel=1, addr 3) returns 0x5A with rd_vld one cycle later.
- Write 0x3C to addr 5, no commit → shadow read = 0x3C, active read and reg_act[5] unchanged. Then pulse commit → reg_act[5]=0x3C after 1 cycle.
- Write 0x77 to addr 2 in the same cycle as commit → reg_act[2]=0x77 next cycle.
- wr_lock=1 while writing 0xFF to addr 1 → acc_err pulse, shadow unchanged. Write to addr REG_NUM → acc_err pulse. Read of addr REG_NUM → rd_data=0, rd_vld=1.
- par_inj on addr 7 → par_err=1 within REG_NUM+1 cycles, par_err_addr=7.
- Inject a second error on addr 9 → par_err_addr stays 7. Pulse err_clr → par_err=1 again with addr 9 captured (9's parity is still bad). Pulse commit, then err_clr → par_err stays 0.

Source files
------------

// File: rtl/hv_cfg_pkg.sv
// Shared definitions for the HV-side configuration register bank:
// register map, default contents and per-register field layouts.
package hv_cfg_pkg;

  localparam int HV_CFG_REG_NUM = 32;
  localparam int HV_CFG_DW      = 8;

  localparam int CFG1_ADDR         = 0;
  localparam int CFG2_ADDR         = 1;
  localparam int CFG3_ADDR         = 2;
  localparam int CFG4_ADDR         = 3;
  localparam int CFG5_ADDR         = 4;
  localparam int CFG6_ADDR         = 5;
  localparam int CFG7_ADDR         = 6;
  localparam int CFG8_ADDR         = 7;
  localparam int CFG9_ADDR         = 8;
  localparam int CFG10_ADDR        = 9;
  localparam int CFG11_ADDR        = 10;
  localparam int CFG12_ADDR        = 11;
  localparam int TRIM_ADDR         = 12;
  localparam int DVDT_ADDR         = 13;
  localparam int ADC_ADDR          = 14;
  localparam int TEST_ADDR         = 15;
  localparam int CMP_ADJ_VREG_ADDR = 16;

  localparam logic [HV_CFG_REG_NUM*HV_CFG_DW-1:0] HV_CFG_RST_VAL = '0;

  // Field views of individual registers; consumers cast reg_act slices to these.
  typedef struct packed {
    logic [2:0] drv_str;
    logic [1:0] dead_time;
    logic       en_slew;
    logic       en_ocp;
    logic       en_drv;
  } cfg1_t;

  typedef struct packed {
    logic [3:0] vref_trim;
    logic [3:0] osc_trim;
  } trim_t;

  typedef struct packed {
    logic [1:0] rise;
    logic [1:0] fall;
    logic [3:0] blank;
  } dvdt_t;

  typedef struct packed {
    logic [1:0] chan_sel;
    logic [2:0] avg;
    logic       cont;
    logic       en_adc;
    logic       rsvd;
  } adc_t;

endpackage

// File: rtl/hv_cfg_scrub.sv
// Background parity scrubber: walks the active copy one register per cycle
// and latches a sticky error with the address of the first failure.
module hv_cfg_scrub
  import hv_cfg_pkg::*;
#(
  parameter int REG_NUM = HV_CFG_REG_NUM,
  parameter int DW      = HV_CFG_DW,
  parameter int AW      = $clog2(REG_NUM)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_NUM*DW-1:0] act,
  input  logic [REG_NUM-1:0]    par,
  input  logic                  err_clr,
  output logic                  par_err,
  output logic [AW-1:0]         par_err_addr
);

  logic [AW-1:0] cnt;
  logic [DW-1:0] word;
  logic          word_par;
  logic          mismatch;

  always_comb begin
    word     = '0;
    word_par = 1'b0;
    for (int i = 0; i < REG_NUM; i++) begin
      if (cnt == AW'(i)) begin
        word     = act[i*DW +: DW];
        word_par = par[i];
      end
    end
  end

  assign mismatch = (^word) != word_par;

  // A fresh mismatch beats err_clr, and a clear in that cycle lets the new address in.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      par_err      <= 1'b0;
      par_err_addr <= '0;
    end else begin
      cnt <= (cnt == AW'(REG_NUM - 1)) ? '0 : cnt + 1'b1;
      if (mismatch) begin
        par_err <= 1'b1;
        if (!par_err || err_clr) par_err_addr <= cnt;
      end else if (err_clr) begin
        par_err <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/hv_cfg_reg_bank.sv
// Shadow/active configuration register bank with atomic commit,
// registered reads, access-error reporting and parity-scrubbed active copy.
module hv_cfg_reg_bank
  import hv_cfg_pkg::*;
#(
  parameter int                    REG_NUM = HV_CFG_REG_NUM,
  parameter int                    DW      = HV_CFG_DW,
  parameter int                    AW      = $clog2(REG_NUM),
  parameter logic [REG_NUM*DW-1:0] RST_VAL = HV_CFG_RST_VAL
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_req,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DW-1:0]         wr_data,
  input  logic                  wr_lock,
  input  logic                  rd_req,
  input  logic [AW-1:0]         rd_addr,
  input  logic                  rd_sel,
  output logic [DW-1:0]         rd_data,
  output logic                  rd_vld,
  input  logic                  commit,
  output logic                  acc_err,
  output logic [REG_NUM*DW-1:0] reg_act,
  input  logic                  par_inj,
  input  logic                  err_clr,
  output logic                  par_err,
  output logic [AW-1:0]         par_err_addr
);

  localparam logic [AW:0] REG_LIMIT = (AW+1)'(REG_NUM);

  logic [DW-1:0]      shadow [REG_NUM];
  logic [DW-1:0]      active [REG_NUM];
  logic [DW-1:0]      fwd    [REG_NUM];
  logic [REG_NUM-1:0] par;
  logic [REG_NUM-1:0] par_nxt;
  logic               wr_ok;
  logic               rd_ok;
  logic               wr_en;

  assign wr_ok = {1'b0, wr_addr} < REG_LIMIT;
  assign rd_ok = {1'b0, rd_addr} < REG_LIMIT;
  assign wr_en = wr_req && !wr_lock && wr_ok;

  // fwd is the shadow copy including this cycle's write, so commit picks it up.
  always_comb begin
    fwd     = shadow;
    par_nxt = par;
    for (int i = 0; i < REG_NUM; i++) begin
      if (wr_en && wr_addr == AW'(i)) fwd[i] = wr_data;
      if (commit) par_nxt[i] = ^fwd[i];
      if (par_inj && wr_addr == AW'(i)) par_nxt[i] = ~par_nxt[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        shadow[i] <= RST_VAL[i*DW +: DW];
        active[i] <= RST_VAL[i*DW +: DW];
        par[i]    <= ^RST_VAL[i*DW +: DW];
      end
    end else begin
      shadow <= fwd;
      if (commit) active <= fwd;
      par <= par_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
      rd_vld  <= 1'b0;
      acc_err <= 1'b0;
    end else begin
      rd_vld  <= rd_req;
      rd_data <= '0;
      if (rd_req && rd_ok) rd_data <= rd_sel ? active[rd_addr] : shadow[rd_addr];
      acc_err <= (wr_req && (wr_lock || !wr_ok)) || (rd_req && !rd_ok);
    end
  end

  for (genvar g = 0; g < REG_NUM; g++) begin : g_flat
    assign reg_act[g*DW +: DW] = active[g];
  end

  hv_cfg_scrub #(
    .REG_NUM (REG_NUM),
    .DW      (DW),
    .AW      (AW)
  ) u_scrub (
    .clk          (clk),
    .rst          (rst),
    .act          (reg_act),
    .par          (par),
    .err_clr      (err_clr),
    .par_err      (par_err),
    .par_err_addr (par_err_addr)
  );

endmodule

// File: tb/tb_hv_cfg_reg_bank.sv
// Self-checking bench for hv_cfg_reg_bank: directed scenarios followed by
// randomized traffic, all compared against a register-level reference model.
module tb_hv_cfg_reg_bank;

  localparam int RN = 24;
  localparam int DW = 8;
  localparam int AW = 5;
  localparam int CW = RN * DW;

  function automatic logic [RN*DW-1:0] mkRst();
    logic [RN*DW-1:0] v;
    for (int i = 0; i < RN; i++) v[i*DW +: DW] = DW'(i * 37 + 11);
    v[3*DW +: DW] = 8'h5A;
    return v;
  endfunction

  localparam logic [RN*DW-1:0] TB_RST = mkRst();

  logic          clk = 1'b0;
  logic          rst, wr_req, wr_lock, rd_req, rd_sel, commit, par_inj, err_clr;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] rd_data;
  logic          rd_vld, acc_err, par_err;
  logic [CW-1:0] reg_act;
  logic [AW-1:0] par_err_addr;

  int checks   = 0;
  int failures = 0;

  // Reference model state: register contents, which parity bits are wrong,
  // sticky error bookkeeping and the scrub position.
  logic [DW-1:0] m_sh  [RN];
  logic [DW-1:0] m_act [RN];
  bit            m_bad [RN];
  logic          m_err;
  logic [AW-1:0] m_addr;
  int            m_pos;
  logic [DW-1:0] e_rd_data;
  logic          e_rd_vld, e_acc;

  always #5 clk = ~clk;

  hv_cfg_reg_bank #(.REG_NUM(RN), .DW(DW), .AW(AW), .RST_VAL(TB_RST)) dut (
    .clk(clk), .rst(rst), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_lock(wr_lock), .rd_req(rd_req), .rd_addr(rd_addr), .rd_sel(rd_sel),
    .rd_data(rd_data), .rd_vld(rd_vld), .commit(commit), .acc_err(acc_err),
    .reg_act(reg_act), .par_inj(par_inj), .err_clr(err_clr), .par_err(par_err),
    .par_err_addr(par_err_addr)
  );

  task automatic checkOutput(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clearInputs();
    rst = 1'b0; wr_req = 1'b0; wr_lock = 1'b0; rd_req = 1'b0; rd_sel = 1'b0;
    commit = 1'b0; par_inj = 1'b0; err_clr = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_data = '0;
  endtask

  // Advance the model by one cycle from the current inputs, clock the DUT, compare.
  task automatic applyStimulus();
    bit wok, rok;
    logic [CW-1:0] flat;
    wok = int'(wr_addr) < RN;
    rok = int'(rd_addr) < RN;
    if (rst) begin
      for (int i = 0; i < RN; i++) begin
        m_sh[i]  = TB_RST[i*DW +: DW];
        m_act[i] = TB_RST[i*DW +: DW];
        m_bad[i] = 1'b0;
      end
      m_err = 1'b0; m_addr = '0; m_pos = 0;
      e_rd_data = '0; e_rd_vld = 1'b0; e_acc = 1'b0;
    end else begin
      e_acc     = (wr_req && (wr_lock || !wok)) || (rd_req && !rok);
      e_rd_vld  = rd_req;
      e_rd_data = (rd_req && rok) ? (rd_sel ? m_act[rd_addr] : m_sh[rd_addr]) : '0;
      if (m_bad[m_pos]) begin
        if (!m_err || err_clr) m_addr = AW'(m_pos);
        m_err = 1'b1;
      end else if (err_clr) begin
        m_err = 1'b0;
      end
      m_pos = (m_pos + 1) % RN;
      if (wr_req && !wr_lock && wok) m_sh[wr_addr] = wr_data;
      if (commit) begin
        m_act = m_sh;
        for (int i = 0; i < RN; i++) m_bad[i] = 1'b0;
      end
      if (par_inj && wok) m_bad[wr_addr] = ~m_bad[wr_addr];
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < RN; i++) flat[i*DW +: DW] = m_act[i];
    checkOutput("rd_vld", CW'(rd_vld), CW'(e_rd_vld));
    checkOutput("rd_data", CW'(rd_data), CW'(e_rd_data));
    checkOutput("acc_err", CW'(acc_err), CW'(e_acc));
    checkOutput("par_err", CW'(par_err), CW'(m_err));
    checkOutput("par_err_addr", CW'(par_err_addr), CW'(m_addr));
    checkOutput("reg_act", reg_act, flat);
    clearInputs();
  endtask

  initial begin
    clearInputs();
    rst = 1'b1; applyStimulus();
    rst = 1'b1; applyStimulus();
    checkOutput("rst_reg3", CW'(reg_act[3*DW +: DW]), CW'(8'h5A));
    checkOutput("rst_par_err", CW'(par_err), CW'(1'b0));

    rd_req = 1'b1; rd_sel = 1'b1; rd_addr = 5'd3; applyStimulus();
    checkOutput("rd_act3", CW'(rd_data), CW'(8'h5A));

    wr_req = 1'b1; wr_addr = 5'd5; wr_data = 8'h3C; applyStimulus();
    rd_req = 1'b1; rd_sel = 1'b0; rd_addr = 5'd5; applyStimulus();
    checkOutput("rd_shadow5", CW'(rd_data), CW'(8'h3C));
    rd_req = 1'b1; rd_sel = 1'b1; rd_addr = 5'd5; applyStimulus();
    checkOutput("rd_act5_old", CW'(rd_data), CW'(TB_RST[5*DW +: DW]));
    checkOutput("reg_act5_old", CW'(reg_act[5*DW +: DW]), CW'(TB_RST[5*DW +: DW]));
    commit = 1'b1; applyStimulus();
    checkOutput("reg_act5_commit", CW'(reg_act[5*DW +: DW]), CW'(8'h3C));

    wr_req = 1'b1; wr_addr = 5'd2; wr_data = 8'h77; commit = 1'b1; applyStimulus();
    checkOutput("reg_act2_fwd", CW'(reg_act[2*DW +: DW]), CW'(8'h77));

    wr_req = 1'b1; wr_lock = 1'b1; wr_addr = 5'd1; wr_data = 8'hFF; applyStimulus();
    checkOutput("acc_err_lock", CW'(acc_err), CW'(1'b1));
    rd_req = 1'b1; rd_addr = 5'd1; applyStimulus();
    checkOutput("rd_shadow1_locked", CW'(rd_data), CW'(TB_RST[1*DW +: DW]));
    wr_req = 1'b1; wr_addr = 5'(RN); wr_data = 8'h11; applyStimulus();
    checkOutput("acc_err_wr_oor", CW'(acc_err), CW'(1'b1));
    rd_req = 1'b1; rd_sel = 1'b1; rd_addr = 5'(RN); applyStimulus();
    checkOutput("rd_oor_vld", CW'(rd_vld), CW'(1'b1));
    checkOutput("rd_oor_data", CW'(rd_data), CW'(0));

    par_inj = 1'b1; wr_addr = 5'd7; applyStimulus();
    for (int k = 0; k < RN + 1 && par_err !== 1'b1; k++) applyStimulus();
    checkOutput("par_err_detect7", CW'(par_err), CW'(1'b1));
    checkOutput("par_err_addr7", CW'(par_err_addr), CW'(7));

    par_inj = 1'b1; wr_addr = 5'd7; applyStimulus();
    par_inj = 1'b1; wr_addr = 5'd9; applyStimulus();
    for (int k = 0; k < RN + 2; k++) applyStimulus();
    checkOutput("par_err_addr_sticky", CW'(par_err_addr), CW'(7));
    err_clr = 1'b1; applyStimulus();
    for (int k = 0; k < RN + 1 && par_err !== 1'b1; k++) applyStimulus();
    checkOutput("par_err_redetect", CW'(par_err), CW'(1'b1));
    checkOutput("par_err_addr9", CW'(par_err_addr), CW'(9));
    commit = 1'b1; applyStimulus();
    err_clr = 1'b1; applyStimulus();
    for (int k = 0; k < RN + 2; k++) applyStimulus();
    checkOutput("par_err_cleared", CW'(par_err), CW'(1'b0));

    for (int n = 0; n < 400; n++) begin
      rst     = ($urandom_range(0, 63) == 0);
      wr_req  = 1'($urandom_range(0, 1));
      wr_lock = ($urandom_range(0, 3) == 0);
      wr_addr = AW'($urandom_range(0, 31));
      wr_data = DW'($urandom);
      rd_req  = 1'($urandom_range(0, 1));
      rd_sel  = 1'($urandom_range(0, 1));
      rd_addr = AW'($urandom_range(0, 31));
      commit  = ($urandom_range(0, 7) == 0);
      par_inj = ($urandom_range(0, 31) == 0);
      err_clr = ($urandom_range(0, 15) == 0);
      applyStimulus();
    end

    rd_req = 1'b1; rd_addr = 5'd4; rst = 1'b1; applyStimulus();
    checkOutput("rst_kills_read", CW'(rd_vld), CW'(1'b0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
